fifo_param: RTL and testbench

Parametrised synchronous FIFO, the successor to the fixed single-mode fifo. It adds configurable width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, sticky-free overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It drops into existing benches through the same data_in/wr_en/rd_en/data_op/full/empty signal set, with the extra outputs added.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_mem.sv | 30 +++
 rtl/fifo_param.sv | 153 +++++++++++++++
 tb/tb_fifo_param.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and elaboration-time helpers for the parametrised FIFO.
package fifo_pkg;

    // Read-port presentation style selected by the FWFT parameter.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Address width for a DEPTH-entry array (DEPTH is a power of two >= 2).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: one extra bit so DEPTH itself is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Map the integer FWFT parameter onto the mode enum.
    function automatic fifo_mode_e mode_of(input int fwft);
        return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH simple dual-port storage: synchronous write, asynchronous read.
// Contents are intentionally not reset; the control logic never exposes an
// unwritten location.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                            clk,
    input  logic                            wr_en,
    input  logic [ptr_width(DEPTH)-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic [ptr_width(DEPTH)-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]           rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the incoming word on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port is a plain combinational lookup.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, overflow/underflow pulses and selectable
// standard or first-word-fall-through read presentation.
//
// Handshake: wr_en and rd_en are requests, not valid/ready pairs. A write is
// accepted when wr_en && !full, a read when rd_en && !empty, both judged on
// the state before the clock edge. A rejected request is dropped and reported
// by a one-cycle overflow/underflow pulse on the following cycle.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            rd_en,
    output logic [DATA_WIDTH-1:0]           data_op,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [cnt_width(DEPTH)-1:0]     count,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int         PW   = ptr_width(DEPTH);
    localparam int         CW   = cnt_width(DEPTH);
    localparam fifo_mode_e MODE = mode_of(FWFT);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    // Reject illegal configurations while elaborating.
    generate
        if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
            $error("fifo_param: DEPTH must be a power of two >= 2");
        end
        if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
            $error("fifo_param: AF_THRESH must lie in 1..DEPTH");
        end
        if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
            $error("fifo_param: AE_THRESH must lie in 0..DEPTH-1");
        end
        if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
            $error("fifo_param: FWFT must be 0 or 1");
        end
    endgenerate

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    // Flags are pure decodes of the registered occupancy.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Acceptance uses pre-edge flags; no write-to-read bypass when empty.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Pointers advance on acceptance and wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Next occupancy: up on write only, down on read only, else hold.
    always_comb begin
        count_nxt = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    // Error pulses flag a rejected request for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    // Read-data presentation depends on the selected mode.
    generate
        if (MODE == FIFO_STD) begin : g_std
            logic [DATA_WIDTH-1:0] data_q;

            // Registered read: capture the head word on an accepted read,
            // otherwise hold (including across underflow).
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                end else if (rd_acc) begin
                    data_q <= rd_data;
                end
            end

            assign data_op = data_q;
        end else begin : g_fwft
            // Head word is shown directly; rd_en pops it. Zero while empty.
            assign data_op = empty ? '0 : rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: one standard-read and one FWFT instance driven from
// directed tasks, with a reference occupancy model and expected-data queues.
module tb_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;
    localparam int CW    = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- standard-read instance ----------------
    logic          s_wr, s_rd;
    logic [DW-1:0] s_din, s_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [CW-1:0] s_cnt;

    fifo_param #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .AF_THRESH (AF), .AE_THRESH (AE), .FWFT (0)
    ) dut_std (
        .clk (clk), .rst (rst), .wr_en (s_wr), .data_in (s_din), .rd_en (s_rd),
        .data_op (s_dout), .full (s_full), .empty (s_empty), .almost_full (s_af),
        .almost_empty (s_ae), .count (s_cnt), .overflow (s_ovf), .underflow (s_udf)
    );

    // ---------------- FWFT instance ----------------
    logic          f_wr, f_rd;
    logic [DW-1:0] f_din, f_dout;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [CW-1:0] f_cnt;

    fifo_param #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .AF_THRESH (AF), .AE_THRESH (AE), .FWFT (1)
    ) dut_fwft (
        .clk (clk), .rst (rst), .wr_en (f_wr), .data_in (f_din), .rd_en (f_rd),
        .data_op (f_dout), .full (f_full), .empty (f_empty), .almost_full (f_af),
        .almost_empty (f_ae), .count (f_cnt), .overflow (f_ovf), .underflow (f_udf)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fexp_q[$];
    int            m_cnt  = 0;
    int            fm_cnt = 0;
    logic [DW-1:0] last_q = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic std_flags();
        check("std_count", 32'(s_cnt), 32'(m_cnt));
        check("std_full",  32'(s_full),  32'(m_cnt == DEPTH));
        check("std_empty", 32'(s_empty), 32'(m_cnt == 0));
        check("std_af",    32'(s_af),    32'(m_cnt >= AF));
        check("std_ae",    32'(s_ae),    32'(m_cnt <= AE));
    endtask

    task automatic fwft_flags();
        check("fwft_count", 32'(f_cnt), 32'(fm_cnt));
        check("fwft_full",  32'(f_full),  32'(fm_cnt == DEPTH));
        check("fwft_empty", 32'(f_empty), 32'(fm_cnt == 0));
        check("fwft_af",    32'(f_af),    32'(fm_cnt >= AF));
        check("fwft_ae",    32'(f_ae),    32'(fm_cnt <= AE));
    endtask

    // ---------------- driver tasks ----------------
    // One clock of the standard instance; inputs change #1 after the edge.
    task automatic std_cycle(input logic w, input logic r, input logic [DW-1:0] d);
        logic          pre_full, pre_empty, w_ok, r_ok;
        logic [DW-1:0] e;
        s_wr = w; s_rd = r; s_din = d;
        pre_full  = (m_cnt == DEPTH);
        pre_empty = (m_cnt == 0);
        w_ok = w && !pre_full;
        r_ok = r && !pre_empty;
        e = last_q;
        if (r_ok) e = exp_q.pop_front();
        if (w_ok) exp_q.push_back(d);
        m_cnt = m_cnt + (w_ok ? 1 : 0) - (r_ok ? 1 : 0);
        @(posedge clk);
        #1;
        s_wr = 1'b0; s_rd = 1'b0;
        check("std_data", 32'(s_dout), 32'(e));
        last_q = e;
        check("std_ovf", 32'(s_ovf), 32'(w && pre_full));
        check("std_udf", 32'(s_udf), 32'(r && pre_empty));
        std_flags();
    endtask

    // One clock of the FWFT instance; checks the head word shown afterwards.
    task automatic fwft_cycle(input logic w, input logic r, input logic [DW-1:0] d);
        logic pre_full, pre_empty, w_ok, r_ok;
        logic [DW-1:0] head;
        f_wr = w; f_rd = r; f_din = d;
        pre_full  = (fm_cnt == DEPTH);
        pre_empty = (fm_cnt == 0);
        w_ok = w && !pre_full;
        r_ok = r && !pre_empty;
        if (r_ok) void'(fexp_q.pop_front());
        if (w_ok) fexp_q.push_back(d);
        fm_cnt = fm_cnt + (w_ok ? 1 : 0) - (r_ok ? 1 : 0);
        @(posedge clk);
        #1;
        f_wr = 1'b0; f_rd = 1'b0;
        head = (fm_cnt == 0) ? '0 : fexp_q[0];
        check("fwft_data", 32'(f_dout), 32'(head));
        check("fwft_ovf", 32'(f_ovf), 32'(w && pre_full));
        check("fwft_udf", 32'(f_udf), 32'(r && pre_empty));
        fwft_flags();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        s_wr = 0; s_rd = 0; s_din = '0;
        f_wr = 0; f_rd = 0; f_din = '0;

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_std_data", 32'(s_dout), 32'h0);
        check("rst_std_ovf",  32'(s_ovf),  32'h0);
        check("rst_std_udf",  32'(s_udf),  32'h0);
        std_flags();
        check("rst_fwft_data", 32'(f_dout), 32'h0);
        fwft_flags();
        @(posedge clk);
        #1 rst = 1'b0;

        // Idle cycles keep reset values.
        std_cycle(1'b0, 1'b0, 8'h00);
        std_cycle(1'b0, 1'b0, 8'h00);

        // Fill with 0x00..0x0F, then one overflow attempt with 0xAA.
        for (int i = 0; i < DEPTH; i++) std_cycle(1'b1, 1'b0, 8'(i));
        std_cycle(1'b1, 1'b0, 8'hAA);
        std_cycle(1'b0, 1'b0, 8'h00);
        // Simultaneous read/write while full: write rejected.
        std_cycle(1'b1, 1'b1, 8'hAB);
        std_cycle(1'b1, 1'b0, 8'h0F);
        // Drain completely, then underflow twice (data must hold).
        for (int i = 0; i < DEPTH; i++) std_cycle(1'b0, 1'b1, 8'h00);
        std_cycle(1'b0, 1'b1, 8'h00);
        std_cycle(1'b1, 1'b1, 8'h77);
        std_cycle(1'b0, 1'b1, 8'h00);

        // Fill to 8, then 20 simultaneous cycles across the pointer wrap.
        for (int i = 0; i < 8; i++) std_cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 20; i++) std_cycle(1'b1, 1'b1, 8'(8'h40 + i));
        for (int i = 0; i < 8; i++) std_cycle(1'b0, 1'b1, 8'h00);

        // Random mixed traffic.
        for (int i = 0; i < 60; i++)
            std_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

        // FWFT: a word written into an empty FIFO shows on the next cycle.
        fwft_cycle(1'b0, 1'b0, 8'h00);
        fwft_cycle(1'b1, 1'b0, 8'h5C);
        fwft_cycle(1'b0, 1'b0, 8'h00);
        fwft_cycle(1'b0, 1'b1, 8'h00);
        fwft_cycle(1'b0, 1'b1, 8'h00);
        fwft_cycle(1'b1, 1'b1, 8'h21);
        for (int i = 0; i < 4; i++) fwft_cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 6; i++) fwft_cycle(1'b1, 1'b1, 8'(8'h90 + i));
        for (int i = 0; i < 20; i++) fwft_cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 20; i++) fwft_cycle(1'b0, 1'b1, 8'h00);

        // Reset asserted mid-cycle with data queued.
        for (int i = 0; i < 5; i++) std_cycle(1'b1, 1'b0, 8'(8'hC0 + i));
        std_cycle(1'b0, 1'b1, 8'h00);
        #3 rst = 1'b1;
        #1;
        exp_q.delete();
        fexp_q.delete();
        m_cnt  = 0;
        fm_cnt = 0;
        last_q = '0;
        check("midrst_data", 32'(s_dout), 32'h0);
        check("midrst_ovf",  32'(s_ovf),  32'h0);
        check("midrst_udf",  32'(s_udf),  32'h0);
        std_flags();
        @(posedge clk);
        #1 rst = 1'b0;
        std_cycle(1'b1, 1'b0, 8'h33);
        std_cycle(1'b0, 1'b1, 8'h00);
        check("midrst_readback", 32'(s_dout), 32'h33);
        std_cycle(1'b0, 1'b0, 8'h00);

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
